// File: rtl/rms_square_accum.sv
// Windowed sum-of-squares accumulator for RMS estimation: squares 4-bit
// samples and publishes the sum of each N-sample window through a valid/ready register.
module rms_square_accum #(
   parameter int unsigned NWIN_LOG2 = 10
) (
   input  logic                   clk_i,
   input  logic                   rst_i,
   input  logic                   sync_i,
   input  logic [3:0]             dat_i,
   output logic [NWIN_LOG2+7:0]   rms_sum_o,
   output logic                   rms_valid_o,
   input  logic                   rms_ready_i,
   output logic                   overrun_o
);

   localparam int unsigned ACC_W = NWIN_LOG2 + 8;

   typedef enum logic {
      IDLE = 1'b0,
      RUN  = 1'b1
   } state_t;

   state_t               state_q, state_d;
   logic [NWIN_LOG2-1:0] cnt_q;
   logic [7:0]           sq_q;
   logic                 v1_q, first1_q, last1_q;
   logic [ACC_W-1:0]     acc_q;
   logic                 v2_q, last2_q;
   logic [ACC_W-1:0]     sum_q;
   logic                 valid_q, ovr_q;
   logic                 publish, handshake;

   always_comb begin
      state_d = state_q;
      if (sync_i) state_d = RUN;
   end

   // A sync on the cycle a window would publish discards that window too.
   always_comb begin
      publish   = v2_q & last2_q & ~sync_i;
      handshake = valid_q & rms_ready_i;
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q  <= IDLE;
         cnt_q    <= '0;
         sq_q     <= '0;
         v1_q     <= 1'b0;
         first1_q <= 1'b0;
         last1_q  <= 1'b0;
         acc_q    <= '0;
         v2_q     <= 1'b0;
         last2_q  <= 1'b0;
         sum_q    <= '0;
         valid_q  <= 1'b0;
         ovr_q    <= 1'b0;
      end else begin
         state_q <= state_d;

         if (sync_i) begin
            cnt_q    <= '0;
            v1_q     <= 1'b0;
            first1_q <= 1'b0;
            last1_q  <= 1'b0;
            acc_q    <= '0;
            v2_q     <= 1'b0;
            last2_q  <= 1'b0;
         end else begin
            if (state_q == RUN) begin
               sq_q     <= {4'b0000, dat_i} * {4'b0000, dat_i};
               v1_q     <= 1'b1;
               first1_q <= (cnt_q == '0);
               last1_q  <= (cnt_q == '1);
               cnt_q    <= cnt_q + 1'b1;
            end else begin
               v1_q <= 1'b0;
            end

            v2_q    <= v1_q;
            last2_q <= v1_q & last1_q;
            // First square of a window replaces the total so windows abut.
            if (v1_q) begin
               if (first1_q) acc_q <= ACC_W'(sq_q);
               else          acc_q <= acc_q + ACC_W'(sq_q);
            end
         end

         if (publish) begin
            sum_q   <= acc_q;
            valid_q <= 1'b1;
            if (valid_q && !rms_ready_i) ovr_q <= 1'b1;
         end else if (handshake) begin
            valid_q <= 1'b0;
         end

         if (sync_i) ovr_q <= 1'b0;
      end
   end

   assign rms_sum_o   = sum_q;
   assign rms_valid_o = valid_q;
   assign overrun_o   = ovr_q;

endmodule

// File: tb/tb_rms_square_accum.sv
// Scoreboard bench for rms_square_accum (N=16): a cycle-level behavioural model
// queues the expected outputs; a monitor compares them against the DUT each cycle.
module tb_rms_square_accum;

   localparam int unsigned NL = 4;
   localparam int unsigned N  = 16;

   logic            clk_i = 1'b0;
   logic            rst_i = 1'b1;
   logic            sync_i = 1'b0;
   logic [3:0]      dat_i = '0;
   logic            rms_ready_i = 1'b0;
   logic [NL+7:0]   rms_sum_o;
   logic            rms_valid_o;
   logic            overrun_o;

   rms_square_accum #(.NWIN_LOG2(NL)) dut (
      .clk_i       (clk_i),
      .rst_i       (rst_i),
      .sync_i      (sync_i),
      .dat_i       (dat_i),
      .rms_sum_o   (rms_sum_o),
      .rms_valid_o (rms_valid_o),
      .rms_ready_i (rms_ready_i),
      .overrun_o   (overrun_o)
   );

   always #5 clk_i = ~clk_i;

   typedef struct {
      int cyc;
      int val;
      bit ovr;
      bit vld;
   } exp_t;

   typedef struct {
      int cyc;
      int val;
   } pub_t;

   exp_t exp_q[$];
   pub_t sched[$];

   int checks = 0;
   int errors = 0;
   int npub   = 0;
   int novr   = 0;

   // behavioural model state
   int cyc     = 0;
   bit running = 0;
   int k       = 0;
   int wsum    = 0;
   bit m_vld   = 0;
   int m_sum   = 0;
   bit m_ovr   = 0;

   task automatic step(input bit r, input bit s, input bit rd, input int d);
      exp_t e;
      bit   pub;
      int   pval;
      @(negedge clk_i);
      rst_i = r; sync_i = s; rms_ready_i = rd; dat_i = 4'(d);
      cyc++;
      if (r) begin
         running = 0; k = 0; wsum = 0;
         m_vld = 0; m_sum = 0; m_ovr = 0;
         sched.delete();
      end else begin
         pub = 0; pval = 0;
         if (sched.size() > 0 && sched[0].cyc == cyc) begin
            pub  = !s;
            pval = sched[0].val;
            void'(sched.pop_front());
         end
         if (pub) begin
            if (m_vld && !rd) begin m_ovr = 1; novr++; end
            m_sum = pval; m_vld = 1; npub++;
         end else if (m_vld && rd) begin
            m_vld = 0;
         end
         if (s) begin
            m_ovr = 0;
            running = 1; k = 0; wsum = 0;
            sched.delete();
         end else if (running) begin
            wsum = (k == 0 ? 0 : wsum) + d * d;
            if (k == N - 1) sched.push_back('{cyc: cyc + 2, val: wsum});
            k = (k + 1) % N;
         end
      end
      e.cyc = cyc; e.val = m_sum; e.ovr = m_ovr; e.vld = m_vld;
      exp_q.push_back(e);
   endtask

   initial begin : monitor
      exp_t e;
      forever begin
         @(posedge clk_i);
         #1;
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checks++;
            if (rms_valid_o !== e.vld) begin
               errors++;
               $display("FAIL valid cyc=%0d got=%b exp=%b", e.cyc, rms_valid_o, e.vld);
            end
            checks++;
            if (rms_sum_o !== (NL+8)'(e.val)) begin
               errors++;
               $display("FAIL sum cyc=%0d got=%0d exp=%0d", e.cyc, rms_sum_o, e.val);
            end
            checks++;
            if (overrun_o !== e.ovr) begin
               errors++;
               $display("FAIL overrun cyc=%0d got=%b exp=%b", e.cyc, overrun_o, e.ovr);
            end
         end
      end
   end

   initial begin : driver
      // reset, then constant 15 with ready=1: 3600 at S+18 and S+34
      repeat (3) step(1, 0, 0, 0);
      repeat (2) step(0, 0, 1, 7);
      step(0, 1, 1, 0);
      repeat (40) step(0, 0, 1, 15);

      // ramp k mod 16 -> 1240
      step(1, 0, 0, 0);
      step(0, 1, 1, 0);
      for (int i = 0; i < 20; i++) step(0, 0, 1, i % 16);

      // ready held low across two windows, then drained, then cleared by sync
      step(1, 0, 0, 0);
      step(0, 1, 0, 0);
      repeat (40) step(0, 0, 0, $urandom_range(0, 15));
      repeat (10) step(0, 0, 1, 3);
      step(0, 1, 0, 0);
      repeat (3) step(0, 0, 0, 2);

      // mid-window resync at S+9
      step(1, 0, 0, 0);
      step(0, 1, 1, 1);
      repeat (8) step(0, 0, 1, 1);
      step(0, 1, 1, 1);
      repeat (30) step(0, 0, 1, 1);

      // reset mid-window, no sync afterwards; then reset+sync together
      step(1, 0, 0, 0);
      step(0, 1, 1, 9);
      repeat (9) step(0, 0, 1, 9);
      step(1, 0, 1, 9);
      repeat (30) step(0, 0, 1, 9);
      step(1, 1, 1, 9);
      repeat (25) step(0, 0, 1, 9);

      // ready only on the second publication cycle (S+34) with old data pending
      step(1, 0, 0, 0);
      step(0, 1, 0, 0);
      for (int i = 1; i <= 40; i++) step(0, 0, (i == 34), $urandom_range(0, 15));

      // randomized traffic
      for (int i = 0; i < 3000; i++)
         step(($urandom_range(0, 999) == 0), ($urandom_range(0, 149) == 0),
              ($urandom_range(0, 2) != 0), $urandom_range(0, 15));

      repeat (3) step(0, 0, 1, 0);
      @(posedge clk_i);
      #2;
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL drain pending=%0d exp=0", exp_q.size());
      end
      checks++;
      if (npub < 20 || novr < 1) begin
         errors++;
         $display("FAIL coverage pubs=%0d overruns=%0d exp>=20,>=1", npub, novr);
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin : watchdog
      #2000000;
      $display("FAIL timeout got=running exp=finished");
      $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
      $fatal(1, "timeout");
   end

endmodule

// File: doc/rms_square_accum.md
RMS_SQUARE_ACCUM -- requirements
Module: rms_square_accum

Interface
REQ-001 SHALL have parameter: NWIN_LOG2, 10, log2 of window length N in samples; legal range 4..16.
REQ-002 SHALL have port: clk_i  input  1  sole clock; all logic on its rising edge.
REQ-003 SHALL have port: rst_i  input  1  reset, synchronous and active-high.
REQ-004 SHALL have port: sync_i  input  1  window-alignment strobe, same strobe that starts the LFSR sample mux.
REQ-005 SHALL have port: dat_i  input  4  unsigned abs-valued sample from the LFSR sample mux, one per clock.
REQ-006 SHALL have port: rms_sum_o  output  NWIN_LOG2+8  sum of squares of the last completed window.
REQ-007 SHALL have port: rms_valid_o  output  1  rms_sum_o holds an unconsumed result.
REQ-008 SHALL have port: rms_ready_i  input  1  consumer accepts rms_sum_o.
REQ-009 SHALL have port: overrun_o  output  1  sticky; an unconsumed result was overwritten.

Function
REQ-010 SHALL implement states IDLE and RUN; IDLE -> RUN on sync_i=1; RUN has no exit other than reset.
REQ-011 SHALL, on the cycle sync_i=1 (either state), clear the sample counter, the accumulator and both pipeline valid bits.
REQ-012 SHALL treat dat_i captured on cycle S+1+k as window sample k, where S is the sync_i cycle; k counts 0..N-1 then wraps to 0 with no gap.
REQ-013 SHALL register dat_i*dat_i (8 bits, max 225) in stage 1, and add stage 1 into the NWIN_LOG2+8-bit accumulator in stage 2.
REQ-014 SHALL not saturate or wrap the accumulator; N*225 always fits in NWIN_LOG2+8 bits.
REQ-015 SHALL load the first square of a new window directly into the accumulator, not added to the previous total, so windows are back-to-back.
REQ-016 SHALL publish a window: rms_sum_o loaded and rms_valid_o=1 on cycle S+N+2 for the first window, then every N cycles.
REQ-017 SHALL complete a handshake when rms_valid_o=1 and rms_ready_i=1 on the same cycle; rms_valid_o drops on the next cycle unless a publication occurs on that cycle.
REQ-018 SHALL, when publication and handshake coincide, load new data and hold rms_valid_o=1; overrun_o is not set.
REQ-019 SHALL, on publication while rms_valid_o=1 and no handshake, overwrite rms_sum_o, hold rms_valid_o=1 and set overrun_o.
REQ-020 SHALL hold rms_sum_o stable while rms_valid_o=1 and no publication occurs.
REQ-021 SHALL discard a partial window on a sync_i that arrives mid-window, and never publish it; a pending result and rms_valid_o are retained.
REQ-022 SHALL clear overrun_o only on rst_i or sync_i.
REQ-023 SHALL ignore dat_i while in IDLE.

Reset
REQ-024 SHALL, on rst_i=1, enter IDLE and zero the counter, accumulator, pipeline, rms_sum_o, rms_valid_o and overrun_o.
REQ-025 SHALL give rst_i priority over sync_i when both are asserted on the same cycle.
REQ-026 SHALL leave all outputs at 0 after reset until the first publication.

Verification (NWIN_LOG2=4, N=16)
REQ-027 SHALL cover: reset, sync at cycle S, dat_i=15 constant, ready=1 -> rms_sum_o=3600, valid pulse 1 cycle at S+18, repeated at S+34.
REQ-028 SHALL cover: dat_i = k mod 16 for sample k -> rms_sum_o=1240 at S+18.
REQ-029 SHALL cover: ready=0 across two windows -> first value held, overwritten at S+34, overrun_o=1; then ready=1 -> valid drops, overrun_o stays 1 until sync.
REQ-030 SHALL cover: sync at S, second sync at S+9, dat_i=1 -> no publication at S+18; rms_sum_o=16 at S+27.
REQ-031 SHALL cover: rst_i at S+10 mid-window -> outputs 0, no publication until a new sync; rst_i with sync_i on the same cycle -> remains IDLE.
REQ-032 SHALL cover: ready=1 exactly on a publication cycle with old data pending -> new data loaded, valid held, overrun_o=0.
